// File: rtl/st_data_aligner.sv
// Store data aligner: lane-places a store, builds byte strobes and issues one or two
// word-aligned write beats on a request/grant port.
module st_data_aligner #(
    parameter bit ALLOW_MISALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [2:0]  st_width,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_strb,
    output logic        st_done,
    output logic        st_err
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    localparam logic [2:0] WIDTH_B = 3'b000;
    localparam logic [2:0] WIDTH_H = 3'b001;
    localparam logic [2:0] WIDTH_W = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ0 = 2'd1,
        S_REQ1 = 2'd2
    } state_e;

    state_e          state_q,     state_d;
    logic            mem_req_q,   mem_req_d;
    logic [AW-1:0]   mem_addr_q,  mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [SW-1:0]   mem_strb_q,  mem_strb_d;
    logic            st_done_q,   st_done_d;
    logic            st_err_q,    st_err_d;
    logic [AW-1:0]   b1_addr_q,   b1_addr_d;
    logic [DW-1:0]   b1_wdata_q,  b1_wdata_d;
    logic [SW-1:0]   b1_strb_q,   b1_strb_d;

    logic [1:0]      off;
    logic [SW-1:0]   base;
    logic            legal;
    logic [2*SW-1:0] m8;
    logic [2*DW-1:0] d64;
    logic            split;

    // Expand a byte strobe into a bit mask over the data word.
    function automatic logic [DW-1:0] lane_mask(input logic [SW-1:0] s);
        logic [DW-1:0] m;
        m = '0;
        for (int i = 0; i < int'(SW); i++) begin
            m[8*i +: 8] = {8{s[i]}};
        end
        return m;
    endfunction

    // Shift the incoming store onto its byte lanes across a two-word window.
    always_comb begin
        off   = st_addr[1:0];
        base  = '0;
        legal = 1'b1;
        unique case (st_width)
            WIDTH_B: base = 4'b0001;
            WIDTH_H: base = 4'b0011;
            WIDTH_W: base = 4'b1111;
            default: legal = 1'b0;
        endcase
        m8    = {4'b0000, base} << off;
        d64   = {32'h0000_0000, st_data} << {off, 3'b000};
        split = |m8[7:4];
    end

    // Next-state and registered-output computation for the beat sequencer.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_strb_d  = mem_strb_q;
        st_done_d   = 1'b0;
        st_err_d    = 1'b0;
        b1_addr_d   = b1_addr_q;
        b1_wdata_d  = b1_wdata_q;
        b1_strb_d   = b1_strb_q;

        unique case (state_q)
            S_IDLE: begin
                if (st_valid) begin
                    if (!legal || (split && !ALLOW_MISALIGN)) begin
                        st_done_d = 1'b1;
                        st_err_d  = 1'b1;
                    end else begin
                        state_d     = S_REQ0;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = {st_addr[31:2], 2'b00};
                        mem_strb_d  = m8[3:0];
                        mem_wdata_d = d64[31:0] & lane_mask(m8[3:0]);
                        b1_addr_d   = {st_addr[31:2] + 30'd1, 2'b00};
                        b1_strb_d   = m8[7:4];
                        b1_wdata_d  = d64[63:32] & lane_mask(m8[7:4]);
                    end
                end
            end
            S_REQ0: begin
                if (mem_gnt) begin
                    if (|b1_strb_q) begin
                        state_d     = S_REQ1;
                        mem_addr_d  = b1_addr_q;
                        mem_strb_d  = b1_strb_q;
                        mem_wdata_d = b1_wdata_q;
                    end else begin
                        state_d   = S_IDLE;
                        mem_req_d = 1'b0;
                        st_done_d = 1'b1;
                    end
                end
            end
            S_REQ1: begin
                if (mem_gnt) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    st_done_d = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any beat in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_strb_q  <= '0;
            st_done_q   <= 1'b0;
            st_err_q    <= 1'b0;
            b1_addr_q   <= '0;
            b1_wdata_q  <= '0;
            b1_strb_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_strb_q  <= mem_strb_d;
            st_done_q   <= st_done_d;
            st_err_q    <= st_err_d;
            b1_addr_q   <= b1_addr_d;
            b1_wdata_q  <= b1_wdata_d;
            b1_strb_q   <= b1_strb_d;
        end
    end

    assign st_ready  = (state_q == S_IDLE);
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_strb  = mem_strb_q;
    assign st_done   = st_done_q;
    assign st_err    = st_err_q;

endmodule
